// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the single-cycle RV32 core.
//
// Sequence:
//   1. Holds the core in reset for RST_CYCLES cycles after `start`.
//   2. Releases the core, starting it from pc_init.
//   3. Counts RUN cycles.
//   4. Ends the run on any of: a halt instruction, a PC that stays the
//      same for STALL_LIMIT cycles, or the MAX_CYCLES budget running out.
//   5. At termination, captures a0 and reports how the run ended.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a run (accepted in IDLE or DONE)
//   pc, instr, a0     core observation: PC, fetched instruction, x10
//   cpu_rst           reset to the core, low only while running
//   pc_init           constant reset PC for the core
//   running, done     phase indicators
//   halted, timeout   termination cause of the last run
//   cycles            RUN cycles executed in the current/last run
//   result            a0 captured at termination
//
// state | meaning
// IDLE  | after reset, waiting for start; core held in reset
// RESET | holding core reset for RST_CYCLES cycles
// RUN   | core released, counting cycles, watching for termination
// DONE  | run finished, status and result held; core held in reset
module cpu_run_ctrl #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int               RST_CYCLES  = 2,
  parameter int               MAX_CYCLES  = 128,
  parameter int               STALL_LIMIT = 4,
  parameter logic [31:0]      HALT_INSN   = 32'h00000073,
  localparam int              CW          = $clog2(MAX_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] a0,
  output logic            cpu_rst,
  output logic [XLEN-1:0] pc_init,
  output logic            running,
  output logic            done,
  output logic            halted,
  output logic            timeout,
  output logic [CW-1:0]   cycles,
  output logic [XLEN-1:0] result
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW  = $clog2(STALL_LIMIT);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [RCW-1:0]    rst_cnt;
  logic [SW-1:0]     stall_cnt;
  logic [SW:0]       stall_inc;
  logic [XLEN-1:0]   prev_pc;
  logic              prev_valid;
  logic [CW-1:0]     cyc_inc;
  logic              pc_same;
  logic              halt_hit;
  logic              stall_hit;
  logic              budget_hit;
  logic              stop_hit;
  logic              cpu_rst_d, running_d, done_d;

  assign pc_init = RESET_PC;

  always_comb begin
    state_d    = state_q;
    cyc_inc    = (cycles == CW'(MAX_CYCLES)) ? cycles : cycles + 1'b1;
    stall_inc  = {1'b0, stall_cnt} + 1'b1;
    pc_same    = prev_valid && (pc == prev_pc);
    halt_hit   = (instr == HALT_INSN);
    // stall_cnt counts repeats after the first sighting of a PC, so the
    // limit is one less than the number of cycles showing that PC.
    stall_hit  = pc_same && (stall_inc == (SW+1)'(STALL_LIMIT - 1));
    budget_hit = (cyc_inc == CW'(MAX_CYCLES));
    stop_hit   = halt_hit || stall_hit || budget_hit;
    case (state_q)
      IDLE:    if (start) state_d = RESET;
      RESET:   if (rst_cnt == '0) state_d = RUN;
      RUN:     if (stop_hit) state_d = DONE;
      DONE:    if (start) state_d = RESET;
      default: state_d = IDLE;
    endcase
    cpu_rst_d = (state_d != RUN);
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rst_cnt    <= '0;
      stall_cnt  <= '0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      cpu_rst    <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      cycles     <= '0;
      result     <= '0;
    end else begin
      state_q <= state_d;
      cpu_rst <= cpu_rst_d;
      running <= running_d;
      done    <= done_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            rst_cnt <= RCW'(RST_CYCLES - 1);
            halted  <= 1'b0;
            timeout <= 1'b0;
          end
        end
        RESET: begin
          if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 1'b1;
          end else begin
            cycles     <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            result     <= '0;
            stall_cnt  <= '0;
            prev_valid <= 1'b0;
          end
        end
        RUN: begin
          cycles     <= cyc_inc;
          prev_pc    <= pc;
          prev_valid <= 1'b1;
          stall_cnt  <= pc_same ? stall_inc[SW-1:0] : '0;
          if (stop_hit) begin
            result  <= a0;
            // a halt wins over the budget when both land on one cycle
            halted  <= halt_hit || stall_hit;
            timeout <= !(halt_hit || stall_hit);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam int RSTC = 2;
  localparam int MAXC = 128;
  localparam int STL  = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] JAL0  = 32'h0000006F;
  localparam logic [31:0] JAL8  = 32'h0080006F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;

  logic [31:0] mem  [16];
  logic [31:0] mem2 [16];
  logic [31:0] cpc = '0, ca0 = '0, cpc2 = '0, ca02 = '0;
  logic [31:0] instr, instr2;

  logic        cpu_rst, running, done, halted, timeout;
  logic [31:0] pc_init, result;
  logic [7:0]  cycles;
  logic        cpu_rst2, running2, done2, halted2, timeout2;
  logic [31:0] pc_init2, result2;
  logic [1:0]  cycles2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pc(cpc), .instr(instr), .a0(ca0),
    .cpu_rst(cpu_rst), .pc_init(pc_init), .running(running), .done(done),
    .halted(halted), .timeout(timeout), .cycles(cycles), .result(result)
  );

  cpu_run_ctrl #(.MAX_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pc(cpc2), .instr(instr2), .a0(ca02),
    .cpu_rst(cpu_rst2), .pc_init(pc_init2), .running(running2), .done(done2),
    .halted(halted2), .timeout(timeout2), .cycles(cycles2), .result(result2)
  );

  function automatic logic [31:0] addi_a0(input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, 5'd10, 7'h13};
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] p, input logic [31:0] i);
    if (i[6:0] == 7'h6F)
      return p + {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    return p + 32'd4;
  endfunction

  function automatic logic [31:0] next_a0(input logic [31:0] a, input logic [31:0] i);
    if (i[6:0] == 7'h13 && i[11:7] == 5'd10 && i[19:15] == 5'd0 && i[14:12] == 3'd0)
      return {{20{i[31]}}, i[31:20]};
    return a;
  endfunction

  function automatic logic [31:0] fetch1(input logic [31:0] p);
    return (p < 32'd64) ? mem[p[5:2]] : NOP;
  endfunction

  assign instr  = fetch1(cpc);
  assign instr2 = (cpc2 < 32'd64) ? mem2[cpc2[5:2]] : NOP;

  // simple core stand-ins
  always @(posedge clk) begin
    if (cpu_rst) begin cpc <= pc_init; ca0 <= '0; end
    else begin cpc <= next_pc(cpc, instr); ca0 <= next_a0(ca0, instr); end
  end
  always @(posedge clk) begin
    if (cpu_rst2) begin cpc2 <= pc_init2; ca02 <= '0; end
    else begin cpc2 <= next_pc(cpc2, instr2); ca02 <= next_a0(ca02, instr2); end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the program instruction by instruction, tracking how
  // long the same PC has been seen in a row.
  task automatic ref_run(output int e_cyc, output bit e_halt, output bit e_to,
                         output logic [31:0] e_res);
    logic [31:0] p, a, last, ins;
    int runlen;
    p = 32'd0; a = 32'd0; last = 32'hFFFF_FFFF; runlen = 0;
    e_cyc = MAXC; e_halt = 0; e_to = 1; e_res = 0;
    for (int n = 1; n <= MAXC; n++) begin
      ins = fetch1(p);
      runlen = (n > 1 && p == last) ? runlen + 1 : 1;
      last = p;
      if (ins == ECALL || runlen >= STL) begin
        e_cyc = n; e_halt = 1; e_to = 0; e_res = a;
        return;
      end
      if (n == MAXC) begin
        e_cyc = n; e_halt = 0; e_to = 1; e_res = a;
        return;
      end
      a = next_a0(a, ins);
      p = next_pc(p, ins);
    end
  endtask

  task automatic run1(input string tag);
    int e_cyc, lat, rst_hi;
    bit e_halt, e_to, seen_low;
    logic [31:0] e_res;
    ref_run(e_cyc, e_halt, e_to, e_res);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check({tag, "/done_clr"}, done, 0);
    check({tag, "/halt_clr"}, halted, 0);
    check({tag, "/to_clr"}, timeout, 0);
    lat = 0;
    rst_hi = cpu_rst ? 1 : 0;
    seen_low = !cpu_rst;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (!seen_low) begin
        if (cpu_rst) rst_hi++;
        else seen_low = 1;
      end
      if (!done && running && ($urandom % 8 == 0)) start = 1'b1;
    end
    start = 1'b0;
    check({tag, "/done_seen"}, done, 1);
    check({tag, "/latency"}, lat, RSTC + e_cyc);
    check({tag, "/rst_hold"}, rst_hi, RSTC);
    check({tag, "/halted"}, halted, e_halt);
    check({tag, "/timeout"}, timeout, e_to);
    check({tag, "/cycles"}, cycles, e_cyc);
    check({tag, "/result"}, result, e_res);
    check({tag, "/cpu_rst"}, cpu_rst, 1);
    check({tag, "/running"}, running, 0);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) mem[i] = NOP;
  endtask

  initial begin
    fill_nop();
    for (int i = 0; i < 16; i++) mem2[i] = NOP;
    mem2[2] = ECALL;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst/cpu_rst", cpu_rst, 1);
    check("rst/running", running, 0);
    check("rst/done", done, 0);
    check("rst/halted", halted, 0);
    check("rst/timeout", timeout, 0);
    check("rst/cycles", cycles, 0);
    check("rst/result", result, 0);
    check("rst/pc_init", pc_init, 0);

    // halt instruction
    mem[0] = addi_a0(12'd7); mem[1] = ECALL;
    run1("halt");
    check("halt/res7", result, 7);
    check("halt/cyc2", cycles, 2);

    // restart from DONE
    mem[0] = addi_a0(12'd9);
    run1("restart");
    check("restart/res9", result, 9);

    // self loop
    fill_nop();
    mem[0] = addi_a0(12'd3); mem[1] = JAL0;
    run1("loop");
    check("loop/cyc5", cycles, 5);
    check("loop/res3", result, 3);
    check("loop/halted", halted, 1);

    // budget
    fill_nop();
    run1("budget");
    check("budget/cyc", cycles, MAXC);
    check("budget/to", timeout, 1);

    // reset in the middle of RUN
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 10 && !running; i++) begin @(posedge clk); #1; end
    check("midrst/running", running, 1);
    repeat (5) @(posedge clk);
    #1;
    check("midrst/cyc5", cycles, 5);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("midrst/cpu_rst", cpu_rst, 1);
    check("midrst/running0", running, 0);
    check("midrst/done", done, 0);
    check("midrst/halted", halted, 0);
    check("midrst/timeout", timeout, 0);
    check("midrst/cycles", cycles, 0);
    check("midrst/result", result, 0);
    mem[0] = addi_a0(12'd7); mem[1] = ECALL;
    run1("after_rst");
    check("after_rst/res7", result, 7);

    // halt and budget on the same cycle
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    for (int i = 0; i < 20 && !done2; i++) begin @(posedge clk); #1; end
    check("simul/done", done2, 1);
    check("simul/halted", halted2, 1);
    check("simul/timeout", timeout2, 0);
    check("simul/cycles", cycles2, 3);

    // random programs
    for (int r = 0; r < 30; r++) begin
      bit no_halt;
      no_halt = ($urandom % 4 == 0);
      for (int i = 0; i < 16; i++) begin
        int k;
        k = $urandom % 16;
        if (no_halt && (k == 12 || k == 13)) k = 6;
        case (k)
          6, 7, 8, 9: mem[i] = NOP;
          10, 11:     mem[i] = JAL8;
          12:         mem[i] = JAL0;
          13:         mem[i] = ECALL;
          default:    mem[i] = addi_a0(12'($urandom));
        endcase
      end
      repeat ($urandom % 4) @(posedge clk);
      run1($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
